// File: rtl/latch_bank_write_ctrl.sv
// Write sequencer for a clockless bank of four 2-bit D latches shared by two requesters.
// It arbitrates round-robin, then drives data and a one-hot enable through setup/open/hold.
module latch_bank_write_ctrl #(
    parameter int OPEN_CYC = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0_valid,
    input  logic [1:0] req0_addr,
    input  logic [1:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [1:0] req1_addr,
    input  logic [1:0] req1_data,
    output logic       req1_ready,
    output logic [3:0] lat_en,
    output logic [1:0] lat_d,
    output logic       busy,
    output logic       wr_done,
    output logic       last_grant
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    localparam logic [2:0] CNT_LOAD = 3'(OPEN_CYC - 1);

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        logic [3:0] oh;
        case (idx)
            2'd0:    oh = 4'b0001;
            2'd1:    oh = 4'b0010;
            2'd2:    oh = 4'b0100;
            2'd3:    oh = 4'b1000;
            default: oh = 4'b0000;
        endcase
        return oh;
    endfunction

    state_t     state_r;
    state_t     state_nxt_s;
    logic [2:0] cnt_r;
    logic [2:0] cnt_nxt_s;
    logic [1:0] addr_r;
    logic [1:0] addr_nxt_s;
    logic [1:0] lat_d_r;
    logic [1:0] lat_d_nxt_s;
    logic       last_grant_r;
    logic       last_grant_nxt_s;
    logic [3:0] lat_en_r;
    logic       busy_r;
    logic       wr_done_r;
    logic       has_win_s;
    logic       win_s;

    // Round-robin arbitration, only meaningful while idle
    always_comb begin
        has_win_s = 1'b0;
        win_s     = 1'b0;
        if (state_r == IDLE) begin
            if (req0_valid && req1_valid) begin
                has_win_s = 1'b1;
                win_s     = ~last_grant_r;
            end else if (req0_valid) begin
                has_win_s = 1'b1;
                win_s     = 1'b0;
            end else if (req1_valid) begin
                has_win_s = 1'b1;
                win_s     = 1'b1;
            end else begin
                has_win_s = 1'b0;
                win_s     = 1'b0;
            end
        end else begin
            has_win_s = 1'b0;
            win_s     = 1'b0;
        end
    end

    // Ready is forced low while reset is held even though the state is already IDLE
    assign req0_ready = rst_n && has_win_s && !win_s;
    assign req1_ready = rst_n && has_win_s && win_s;

    // Next-state, capture and open-counter logic
    always_comb begin
        state_nxt_s      = state_r;
        cnt_nxt_s        = cnt_r;
        addr_nxt_s       = addr_r;
        lat_d_nxt_s      = lat_d_r;
        last_grant_nxt_s = last_grant_r;
        case (state_r)
            IDLE: begin
                if (has_win_s) begin
                    state_nxt_s      = SETUP;
                    addr_nxt_s       = win_s ? req1_addr : req0_addr;
                    lat_d_nxt_s      = win_s ? req1_data : req0_data;
                    last_grant_nxt_s = win_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETUP: begin
                state_nxt_s = OPEN;
                cnt_nxt_s   = CNT_LOAD;
            end
            OPEN: begin
                if (cnt_r == 3'd0) begin
                    state_nxt_s = HOLD;
                end else begin
                    cnt_nxt_s = cnt_r - 3'd1;
                end
            end
            HOLD: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
            default: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = 3'd0;
            end
        endcase
    end

    // State and outputs registered from the next state so enables are glitch-free flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            addr_r       <= 2'd0;
            lat_d_r      <= 2'd0;
            last_grant_r <= 1'b1;
            lat_en_r     <= 4'b0000;
            busy_r       <= 1'b0;
            wr_done_r    <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            cnt_r        <= cnt_nxt_s;
            addr_r       <= addr_nxt_s;
            lat_d_r      <= lat_d_nxt_s;
            last_grant_r <= last_grant_nxt_s;
            lat_en_r     <= (state_nxt_s == OPEN) ? onehot4(addr_nxt_s) : 4'b0000;
            busy_r       <= (state_nxt_s != IDLE);
            wr_done_r    <= (state_nxt_s == HOLD);
        end
    end

    assign lat_en     = lat_en_r;
    assign lat_d      = lat_d_r;
    assign busy       = busy_r;
    assign wr_done    = wr_done_r;
    assign last_grant = last_grant_r;

endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Scoreboard bench for latch_bank_write_ctrl: directed writes, contention, busy
// ignoring, reset mid-open, plus a second instance built with a one-cycle open window.
module tb_latch_bank_write_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req0_valid, req1_valid, req0_ready, req1_ready;
    logic [1:0] req0_addr, req0_data, req1_addr, req1_data;
    logic [3:0] lat_en;
    logic [1:0] lat_d;
    logic       busy, wr_done, last_grant;

    logic       b_rst_n;
    logic       b_req0_valid, b_req1_valid, b_req0_ready, b_req1_ready;
    logic [1:0] b_req0_addr, b_req0_data, b_req1_addr, b_req1_data;
    logic [3:0] b_lat_en;
    logic [1:0] b_lat_d;
    logic       b_busy, b_wr_done, b_last_grant;

    latch_bank_write_ctrl #(.OPEN_CYC(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .lat_en(lat_en), .lat_d(lat_d), .busy(busy), .wr_done(wr_done), .last_grant(last_grant)
    );

    latch_bank_write_ctrl #(.OPEN_CYC(1)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_req0_valid), .req0_addr(b_req0_addr), .req0_data(b_req0_data), .req0_ready(b_req0_ready),
        .req1_valid(b_req1_valid), .req1_addr(b_req1_addr), .req1_data(b_req1_data), .req1_ready(b_req1_ready),
        .lat_en(b_lat_en), .lat_d(b_lat_d), .busy(b_busy), .wr_done(b_wr_done), .last_grant(b_last_grant)
    );

    typedef struct packed {
        logic [1:0] addr;
        logic [1:0] data;
        logic       who;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] bank [4];
    int         checks = 0;
    int         errors = 0;

    // Single-write expectations for cycles 1..5 after the accept cycle
    logic [3:0] t1_en   [1:5] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0000};
    logic       t1_busy [1:5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       t1_done [1:5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    // One-cycle-open build, cycles 0..4 from the first accept
    logic       b_rdy   [0:4] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [3:0] b_en    [0:4] = '{4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000};
    logic       b_done  [0:4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] a, input logic [1:0] d, input logic w);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.who  = w;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        repeat (2) @(negedge clk);
    endtask

    // Behavioural latch bank: enable is only ever high with stable data, so edge sampling suffices
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (lat_en[i]) bank[i] <= lat_d;
        end
    end

    // Scoreboard monitor: each wr_done pulse retires the oldest expected write
    always @(negedge clk) begin : mon_wr
        exp_t e;
        if (rst_n && wr_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_wr_done actual=1 required=0 at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                chk("wr_lat_d", {6'd0, lat_d}, {6'd0, e.data});
                chk("wr_last_grant", {7'd0, last_grant}, {7'd0, e.who});
                chk("wr_latch_content", {6'd0, bank[e.addr]}, {6'd0, e.data});
            end
        end
    end

    logic [3:0] prev_en;
    logic [1:0] prev_d;
    logic       prev_ok = 1'b0;

    // Enable must be zero/one-hot, and data frozen while enabled and one cycle either side
    always @(negedge clk) begin
        if (rst_n) begin
            chk("en_onehot", {7'd0, (lat_en & (lat_en - 4'd1)) == 4'd0}, 8'd1);
            if (prev_ok && ((lat_en != 4'd0) || (prev_en != 4'd0)))
                chk("d_stable", {6'd0, lat_d}, {6'd0, prev_d});
        end
        prev_en <= lat_en;
        prev_d  <= lat_d;
        prev_ok <= rst_n;
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; b_rst_n = 1'b0;
        req0_valid = 1'b1; req0_addr = 2'd2; req0_data = 2'd3;
        req1_valid = 1'b0; req1_addr = 2'd0; req1_data = 2'd0;
        b_req0_valid = 1'b0; b_req0_addr = 2'd0; b_req0_data = 2'd0;
        b_req1_valid = 1'b0; b_req1_addr = 2'd0; b_req1_data = 2'd0;
        repeat (2) @(negedge clk);

        chk("rst_lat_en", {4'd0, lat_en}, 8'h00);
        chk("rst_lat_d", {6'd0, lat_d}, 8'h00);
        chk("rst_busy", {7'd0, busy}, 8'h00);
        chk("rst_wr_done", {7'd0, wr_done}, 8'h00);
        chk("rst_last_grant", {7'd0, last_grant}, 8'h01);
        chk("rst_ready0", {7'd0, req0_ready}, 8'h00);

        // Single write req0 addr2 data 11, accept on the first edge after release
        rst_n = 1'b1;
        push(2'd2, 2'd3, 1'b0);
        #1 chk("t1_ready0", {7'd0, req0_ready}, 8'h01);
        chk("t1_ready1", {7'd0, req1_ready}, 8'h00);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
            chk("t1_lat_d", {6'd0, lat_d}, 8'h03);
            chk("t1_lat_en", {4'd0, lat_en}, {4'd0, t1_en[c]});
            chk("t1_busy", {7'd0, busy}, {7'd0, t1_busy[c]});
            chk("t1_wr_done", {7'd0, wr_done}, {7'd0, t1_done[c]});
        end

        // Busy ignoring: req1 appears during req0 OPEN and must wait for IDLE
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 2'd2;
        push(2'd1, 2'd2, 1'b0);
        #1 chk("t2_ready0", {7'd0, req0_ready}, 8'h01);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
            if (c == 2) begin
                req1_valid = 1'b1; req1_addr = 2'd0; req1_data = 2'd1;
                push(2'd0, 2'd1, 1'b1);
            end
            if (c == 6) req1_valid = 1'b0;
            #1;
            if (c >= 2 && c <= 4) begin
                chk("t2_ready1_busy", {7'd0, req1_ready}, 8'h00);
                chk("t2_lat_d_hidden", {6'd0, lat_d}, 8'h02);
            end
            if (c == 5) chk("t2_ready1_idle", {7'd0, req1_ready}, 8'h01);
        end
        drain(30);

        // Contention from reset: strict alternation 0,1,0,1 every 5 cycles
        rst_n = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1; req0_addr = 2'd0; req0_data = 2'd1;
        req1_valid = 1'b1; req1_addr = 2'd3; req1_data = 2'd2;
        push(2'd0, 2'd1, 1'b0); push(2'd3, 2'd2, 1'b1);
        push(2'd0, 2'd1, 1'b0); push(2'd3, 2'd2, 1'b1);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (c > 0) @(negedge clk);
            if (c == 16) begin
                req0_valid = 1'b0;
                req1_valid = 1'b0;
            end
            #1;
            if (c % 5 == 0) begin
                chk("ct_ready0", {7'd0, req0_ready}, {7'd0, ((c / 5) % 2) == 0});
                chk("ct_ready1", {7'd0, req1_ready}, {7'd0, ((c / 5) % 2) == 1});
            end else if (c < 16) begin
                chk("ct_no_ready", {7'd0, req0_ready | req1_ready}, 8'h00);
            end
            if (c % 5 == 1) chk("ct_last_grant", {7'd0, last_grant}, {7'd0, ((c / 5) % 2) == 1});
        end
        drain(30);

        // Reset asserted in the first OPEN cycle of a req1 write to latch 1
        req1_valid = 1'b1; req1_addr = 2'd1; req1_data = 2'd1;
        #1 chk("rm_ready1", {7'd0, req1_ready}, 8'h01);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        chk("rm_open_en", {4'd0, lat_en}, 8'h02);
        rst_n = 1'b0;
        #1;
        chk("rm_lat_en", {4'd0, lat_en}, 8'h00);
        chk("rm_lat_d", {6'd0, lat_d}, 8'h00);
        chk("rm_busy", {7'd0, busy}, 8'h00);
        chk("rm_last_grant", {7'd0, last_grant}, 8'h01);
        chk("rm_bank0", {6'd0, bank[0]}, 8'h01);
        chk("rm_bank2", {6'd0, bank[2]}, 8'h03);
        chk("rm_bank3", {6'd0, bank[3]}, 8'h02);
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_addr = 2'd1; req0_data = 2'd3;
        push(2'd1, 2'd3, 1'b0);
        #1 chk("rm_post_ready0", {7'd0, req0_ready}, 8'h01);
        @(negedge clk);
        req0_valid = 1'b0;
        drain(30);

        // One-cycle open window build: enable high one cycle, next accept 4 cycles later
        b_req0_valid = 1'b1; b_req0_addr = 2'd3; b_req0_data = 2'd1;
        b_rst_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            chk("b_ready0", {7'd0, b_req0_ready}, {7'd0, b_rdy[c]});
            chk("b_lat_en", {4'd0, b_lat_en}, {4'd0, b_en[c]});
            chk("b_wr_done", {7'd0, b_wr_done}, {7'd0, b_done[c]});
            if (c >= 1) chk("b_lat_d", {6'd0, b_lat_d}, 8'h01);
        end
        b_req0_valid = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
